// File: rtl/func_gen_pkg.sv
// Shared types and constants for the function-generator datapath and the
// DAC serial transmitter that consumes its waveform samples.
package func_gen_pkg;

    // One unsigned waveform sample as produced by the generator.
    typedef logic [7:0] signal_t;

    // Serial transmitter control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } dac_state_t;

    localparam int unsigned DAC_FRAME_BITS = 16;
    localparam int unsigned DAC_BIT_W      = 4;   // bit index 15..0
    localparam int unsigned DAC_DIV_W      = 8;   // SCLK half-period divider
    localparam int unsigned DAC_HOLD_W     = 4;   // SYNC_N high time counter

    // Scale a sample by gain and place the top 12 product bits in the low
    // 12 bits of the DAC word; the upper nibble is the DAC command field (0).
    function automatic logic [DAC_FRAME_BITS-1:0] dac_frame(
        input signal_t     sample,
        input logic [7:0]  gain
    );
        logic [15:0] product;
        product = 16'(sample) * 16'(gain);
        return {4'b0000, product[15:4]};
    endfunction

endpackage

// File: rtl/dac_sclk_div.sv
// SCLK half-period divider: emits a one-cycle tick every CLK_DIV cycles
// while enabled; the count restarts from zero whenever enable drops.
module dac_sclk_div
    import func_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [DAC_DIV_W-1:0] DIV_LAST = DAC_DIV_W'(CLK_DIV - 1);

    logic [DAC_DIV_W-1:0] cnt_q;

    // Free-run while enabled, wrapping at CLK_DIV-1; held clear otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!en_i || (cnt_q == DIV_LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = en_i && (cnt_q == DIV_LAST);

endmodule

// File: rtl/dac_spi_tx.sv
// DAC serial transmitter: scales an accepted waveform sample by gain and
// shifts the resulting 16-bit word out MSB first with SCLK idling high.
module dac_spi_tx
    import func_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned SYNC_HOLD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [7:0] sample_data,
    input  logic [7:0] gain,
    output logic       sample_ready,
    output logic       spi_sclk,
    output logic       spi_sync_n,
    output logic       spi_din,
    output logic       frame_done
);

    localparam logic [DAC_HOLD_W-1:0] HOLD_LAST = DAC_HOLD_W'(SYNC_HOLD - 1);
    localparam logic [DAC_HOLD_W-1:0] HOLD_PRE  = DAC_HOLD_W'(SYNC_HOLD - 2);

    dac_state_t                 state_q;
    logic [DAC_FRAME_BITS-1:0]  frame_q;
    logic [DAC_FRAME_BITS-1:0]  frame_d;
    logic [DAC_BIT_W-1:0]       bit_q;
    logic [DAC_HOLD_W-1:0]      hold_cnt_q;
    logic                       sclk_q;
    logic                       sync_n_q;
    logic                       din_q;
    logic                       done_q;
    logic                       half_tick;

    // Word to be latched if a sample is accepted this cycle.
    assign frame_d = dac_frame(sample_data, gain);

    dac_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == ST_SHIFT),
        .tick_o (half_tick)
    );

    // Frame sequencer: accept, shift 16 bits on divider ticks, hold SYNC_N high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            bit_q      <= '0;
            hold_cnt_q <= '0;
            sclk_q     <= 1'b1;
            sync_n_q   <= 1'b1;
            din_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (sample_valid) begin
                        state_q  <= ST_SHIFT;
                        frame_q  <= frame_d;
                        bit_q    <= DAC_BIT_W'(DAC_FRAME_BITS - 1);
                        sclk_q   <= 1'b1;
                        sync_n_q <= 1'b0;
                        din_q    <= frame_d[DAC_FRAME_BITS-1];
                    end
                end
                ST_SHIFT: begin
                    if (half_tick) begin
                        if (sclk_q) begin
                            // End of high phase: falling edge, data held.
                            sclk_q <= 1'b0;
                        end else if (bit_q == '0) begin
                            // Last bit done: release the frame.
                            state_q    <= ST_HOLD;
                            sclk_q     <= 1'b1;
                            sync_n_q   <= 1'b1;
                            din_q      <= 1'b0;
                            hold_cnt_q <= '0;
                            done_q     <= (HOLD_LAST == '0);
                        end else begin
                            // Rising edge launches the next bit.
                            sclk_q <= 1'b1;
                            bit_q  <= bit_q - 1'b1;
                            din_q  <= frame_q[bit_q - 1'b1];
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q    <= ST_IDLE;
                        hold_cnt_q <= '0;
                        done_q     <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                        // Pulse lands on the final hold cycle.
                        done_q     <= (hold_cnt_q == HOLD_PRE);
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    sclk_q   <= 1'b1;
                    sync_n_q <= 1'b1;
                    din_q    <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign sample_ready = (state_q == ST_IDLE) && !rst;
    assign spi_sclk     = sclk_q;
    assign spi_sync_n   = sync_n_q;
    assign spi_din      = din_q;
    assign frame_done   = done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Randomized bench for dac_spi_tx: two instances (CLK_DIV=4/SYNC_HOLD=2 and
// CLK_DIV=1/SYNC_HOLD=1), each frame decoded from the pins and compared with
// an arithmetic model of the scaled sample and the frame timing rules.
module tb_dac_spi_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst          [2];
    logic       sample_valid [2];
    logic [7:0] sample_data  [2];
    logic [7:0] gain         [2];
    logic       sample_ready [2];
    logic       spi_sclk     [2];
    logic       spi_sync_n   [2];
    logic       spi_din      [2];
    logic       frame_done   [2];

    int vectors     = 0;
    int miscompares = 0;

    dac_spi_tx #(.CLK_DIV(4), .SYNC_HOLD(2)) u_dut0 (
        .clk          (clk),
        .rst          (rst[0]),
        .sample_valid (sample_valid[0]),
        .sample_data  (sample_data[0]),
        .gain         (gain[0]),
        .sample_ready (sample_ready[0]),
        .spi_sclk     (spi_sclk[0]),
        .spi_sync_n   (spi_sync_n[0]),
        .spi_din      (spi_din[0]),
        .frame_done   (frame_done[0])
    );

    dac_spi_tx #(.CLK_DIV(1), .SYNC_HOLD(1)) u_dut1 (
        .clk          (clk),
        .rst          (rst[1]),
        .sample_valid (sample_valid[1]),
        .sample_data  (sample_data[1]),
        .gain         (gain[1]),
        .sample_ready (sample_ready[1]),
        .spi_sclk     (spi_sclk[1]),
        .spi_sync_n   (spi_sync_n[1]),
        .spi_din      (spi_din[1]),
        .frame_done   (frame_done[1])
    );

    function automatic int cd_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int sh_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one sample on instance d, then observe the pins until ready returns.
    task automatic run_frame(input int d, input logic [7:0] s, input logic [7:0] g,
                             input bit keep_valid, input bit gain_zero_mid);
        int          waitc;
        int          low_cnt, sck_low, nbits, done_cnt, done_k, end_k, bad_edge, bad_idle;
        logic [15:0] exp_frame;
        logic [15:0] got;
        bit          prev_low, prev_sck, prev_din;

        waitc = 0;
        while (sample_ready[d] !== 1'b1 && waitc < 5000) begin
            @(negedge clk);
            waitc++;
        end
        check("ready_before_accept", 32'(sample_ready[d]), 32'd1);

        exp_frame = 16'((32'(s) * 32'(g)) >> 4);
        sample_valid[d] = 1'b1;
        sample_data[d]  = s;
        gain[d]         = g;

        low_cnt = 0; sck_low = 0; nbits = 0; done_cnt = 0; done_k = -1; end_k = -1;
        bad_edge = 0; bad_idle = 0; got = '0;
        prev_low = 1'b0; prev_sck = 1'b1; prev_din = 1'b0;

        for (int k = 1; k < 4000; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("first_sync_n", 32'(spi_sync_n[d]), 32'd0);
                check("first_sclk",   32'(spi_sclk[d]),   32'd1);
                check("first_din",    32'(spi_din[d]),    32'(exp_frame[15]));
            end
            if (sample_ready[d] === 1'b1) begin
                end_k = k;
                break;
            end
            if (frame_done[d] === 1'b1) begin
                done_cnt++;
                done_k = k;
            end
            if (spi_sync_n[d] === 1'b0) begin
                low_cnt++;
                if (spi_sclk[d] === 1'b0) sck_low++;
                if (prev_low && prev_sck && spi_sclk[d] === 1'b0) begin
                    got = {got[14:0], spi_din[d]};
                    nbits++;
                end
                if (prev_low && (spi_din[d] !== prev_din) && !(!prev_sck && spi_sclk[d] === 1'b1))
                    bad_edge++;
                prev_low = 1'b1;
            end else begin
                if (spi_sclk[d] !== 1'b1 || spi_din[d] !== 1'b0) bad_idle++;
                prev_low = 1'b0;
            end
            prev_sck = spi_sclk[d];
            prev_din = spi_din[d];
            // Inputs are scrambled while the frame is in flight.
            sample_valid[d] = keep_valid ? 1'b1 : 1'($urandom_range(0, 1));
            sample_data[d]  = 8'($urandom);
            gain[d]         = gain_zero_mid ? 8'h00 : 8'($urandom);
        end

        check("frame_word",      32'(got),     32'(exp_frame));
        check("bit_count",       32'(nbits),   32'd16);
        check("sync_low_cycles", 32'(low_cnt), 32'(32 * cd_of(d)));
        check("sclk_low_cycles", 32'(sck_low), 32'(16 * cd_of(d)));
        check("done_pulses",     32'(done_cnt), 32'd1);
        check("done_position",   32'(done_k),  32'(end_k - 1));
        check("accept_to_ready", 32'(end_k),   32'(32 * cd_of(d) + sh_of(d) + 1));
        check("din_edge_align",  32'(bad_edge), 32'd0);
        check("idle_pin_levels", 32'(bad_idle), 32'd0);
        if (!keep_valid) sample_valid[d] = 1'b0;
        $display("dut%0d sample=%02h gain=%02h frame=%04h expected=%04h period=%0d",
                 d, s, g, got, exp_frame, end_k);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; sample_valid[d] = 1'b0; sample_data[d] = '0; gain[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ready",  32'(sample_ready[d]), 32'd0);
            check("rst_sclk",   32'(spi_sclk[d]),     32'd1);
            check("rst_sync_n", 32'(spi_sync_n[d]),   32'd1);
            check("rst_din",    32'(spi_din[d]),      32'd0);
            check("rst_done",   32'(frame_done[d]),   32'd0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        check("ready_after_rst0", 32'(sample_ready[0]), 32'd1);
        check("ready_after_rst1", 32'(sample_ready[1]), 32'd1);

        // Directed values and boundaries on the slow instance.
        run_frame(0, 8'h80, 8'h10, 1'b0, 1'b0);
        run_frame(0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        run_frame(0, 8'hFF, 8'h00, 1'b0, 1'b0);
        run_frame(0, 8'hFF, 8'h10, 1'b0, 1'b0);
        // Gain dropped to zero mid-frame, then a frame at gain zero.
        run_frame(0, 8'hA5, 8'h10, 1'b0, 1'b1);
        run_frame(0, 8'hA5, 8'h00, 1'b0, 1'b0);
        // Back-to-back frames with valid held high.
        for (int i = 0; i < 4; i++)
            run_frame(0, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
        sample_valid[0] = 1'b0;
        for (int i = 0; i < 12; i++)
            run_frame(0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);

        // Fastest configuration.
        run_frame(1, 8'h80, 8'h10, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            run_frame(1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            run_frame(1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
        sample_valid[1] = 1'b0;

        // Reset in the middle of bit 7, then a fresh frame.
        @(negedge clk);
        check("abort_ready", 32'(sample_ready[0]), 32'd1);
        sample_valid[0] = 1'b1; sample_data[0] = 8'h5A; gain[0] = 8'hFF;
        @(negedge clk);
        sample_valid[0] = 1'b0;
        repeat (65) @(negedge clk);
        check("abort_pre_sync_n", 32'(spi_sync_n[0]), 32'd0);
        #2 rst[0] = 1'b1;
        #1;
        check("abort_sync_n", 32'(spi_sync_n[0]),   32'd1);
        check("abort_sclk",   32'(spi_sclk[0]),     32'd1);
        check("abort_din",    32'(spi_din[0]),      32'd0);
        check("abort_done",   32'(frame_done[0]),   32'd0);
        check("abort_ready0", 32'(sample_ready[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        @(negedge clk);
        check("abort_ready1", 32'(sample_ready[0]), 32'd1);
        run_frame(0, 8'h3C, 8'h10, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dac_spi_tx.md
DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter CLK_DIV SHALL default to 4 and set the clk cycles per SCLK half-period (legal range 1..255).
REQ-003 Parameter SYNC_HOLD SHALL default to 2 and set the clk cycles SYNC_N stays high between frames (legal range 1..15).
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 sample_valid  in  1  upstream waveform sample (signal_waveform of the generator) is present.
REQ-007 sample_data  in  8  unsigned waveform sample.
REQ-008 gain  in  8  amplitude scale, sampled at accept.
REQ-009 sample_ready  out  1  block can accept a sample this cycle.
REQ-010 spi_sclk  out  1  DAC serial clock, idle high.
REQ-011 spi_sync_n  out  1  DAC frame select, active low.
REQ-012 spi_din  out  1  DAC serial data, MSB first.
REQ-013 frame_done  out  1  one-cycle pulse at frame completion.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and HOLD only.
REQ-015 A sample SHALL be accepted on a rising clk edge in IDLE with sample_valid=1; sample_ready SHALL equal (state==IDLE).
REQ-016 At accept: product = sample_data*gain (16-bit unsigned); code = product[15:4] (12 bits, truncation, no rounding); frame = {4'b0000, code}.
REQ-017 The cycle after accept: state=SHIFT, spi_sync_n=0, spi_sclk=1, spi_din=frame[15].
REQ-018 In SHIFT, each bit SHALL occupy 2*CLK_DIV cycles: SCLK high CLK_DIV cycles, then low CLK_DIV cycles; spi_din changes only together with an SCLK rising transition, so it is stable across each falling edge.
REQ-019 After the low phase of bit 0 completes: state=HOLD, spi_sync_n=1, spi_sclk=1, spi_din=0.
REQ-020 HOLD SHALL last SYNC_HOLD cycles; on the last HOLD cycle frame_done=1, and the next cycle state=IDLE.
REQ-021 Frame period from accept to next possible accept SHALL be 1+32*CLK_DIV+SYNC_HOLD cycles.
REQ-022 sample_valid and sample_data SHALL be ignored outside IDLE; no buffering, no error flag.
REQ-023 gain and sample_data changes during SHIFT/HOLD SHALL NOT alter the frame in flight.
REQ-024 Boundaries: gain=0 -> code 0x000; sample=255, gain=255 -> code 0xFE0; sample=255, gain=16 -> code 0x0FF.
REQ-025 Bit counter SHALL be 4 bits and count 15 down to 0; divider counter SHALL be 8 bits and never wrap in a legal configuration.

Reset
REQ-026 While rst=1 (any state, including mid-frame): state=IDLE, spi_sclk=1, spi_sync_n=1, spi_din=0, frame_done=0, counters and frame register zero.
REQ-027 sample_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst deasserts.
REQ-028 A frame aborted by reset SHALL NOT be resumed; the next accept starts a fresh frame.

Structure
REQ-029 The state enum dac_state_t and the frame-width constant DAC_FRAME_BITS=16 SHALL live in the shared package func_gen_pkg alongside signal_t.
REQ-030 The SCLK half-period divider SHALL be one sub-module, dac_sclk_div, that outputs a one-cycle phase-toggle tick every CLK_DIV cycles while enabled and is cleared on disable.

Verification
REQ-031 CLK_DIV=4, SYNC_HOLD=2, sample=0x80, gain=0x10 -> SPI frame 0x0080 MSB first; SYNC_N low for exactly 128 cycles; frame_done one cycle; ready returns 131 cycles after accept.
REQ-032 sample=0xFF, gain=0xFF -> frame 0x0FE0; gain=0x00 -> frame 0x0000.
REQ-033 Hold sample_valid=1 continuously with changing data -> back-to-back frames each carrying the value present on its accept cycle; no sample accepted during SHIFT/HOLD.
REQ-034 Assert rst at bit 7 of a frame -> SYNC_N=1, SCLK=1, DIN=0 within the same cycle (asynchronous); after release, next frame with sample 0x3C, gain 0x10 reads 0x003C.
REQ-035 CLK_DIV=1, SYNC_HOLD=1 -> SCLK period 2 cycles, frame 32 cycles SYNC_N low, accept-to-accept period 34 cycles.
REQ-036 Change gain mid-frame from 0x10 to 0x00 -> current frame unchanged; next frame 0x0000.
